// File: rtl/alu_cmd_if.sv
// Bundles the sequencer request, ALU command/result and upstream response signals of the ALU issuer.
// The master modport is the issuer's view and the slave modport is the environment's view.
interface alu_cmd_if #(
  parameter int DW = 16
);
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          alu_valid;
  logic          alu_ready;
  logic [1:0]    alu_control;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          alu_rsp_valid;
  logic [DW-1:0] alu_y;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_y;
  logic          rsp_err;

  modport master (
    input  req_valid, req_op, req_a, req_b, alu_ready, alu_rsp_valid, alu_y, rsp_ready,
    output req_ready, alu_valid, alu_control, alu_a, alu_b, rsp_valid, rsp_y, rsp_err
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, alu_ready, alu_rsp_valid, alu_y, rsp_ready,
    input  req_ready, alu_valid, alu_control, alu_a, alu_b, rsp_valid, rsp_y, rsp_err
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: encodes one-hot requests, issues one command at a time, and returns the result or an error.
// Optional ALU_CMD_TIMEOUT_EN adds a WAIT-state watchdog of TIMEOUT_CYC cycles.
module alu_cmd_issuer #(
  parameter int DW = 16
`ifdef ALU_CMD_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic      clk,
  input  logic      rst,
  alu_cmd_if.master bus,
  output logic      busy_o
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] y_q, y_d;
  logic          err_q, err_d;
  logic [1:0]    enc;

`ifdef ALU_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          tmo_hit;

  assign tmo_hit = (wcnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    wcnt_d = wcnt_q;
    if (state_q == S_ISSUE) begin
      wcnt_d = '0;
    end else if (state_q == S_WAIT) begin
      wcnt_d = wcnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end
`endif

  // Anything other than a clean one-hot pattern maps to the invalid code.
  always_comb begin
    case (bus.req_op)
      3'b001:  enc = 2'd0;
      3'b010:  enc = 2'd1;
      3'b100:  enc = 2'd2;
      default: enc = 2'd3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          a_d    = bus.req_a;
          b_d    = bus.req_b;
          ctrl_d = enc;
          if (enc == 2'd3) begin
            y_d     = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (bus.alu_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.alu_rsp_valid) begin
          y_d     = bus.alu_y;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
`ifdef ALU_CMD_TIMEOUT_EN
        else if (tmo_hit) begin
          y_d     = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
`endif
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command/result holding registers; outputs are gated by state so these need no reset.
  always_ff @(posedge clk) begin
    ctrl_q <= ctrl_d;
    a_q    <= a_d;
    b_q    <= b_d;
    y_q    <= y_d;
    err_q  <= err_d;
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.alu_valid   = (state_q == S_ISSUE);
  assign bus.alu_control = (state_q == S_ISSUE) ? ctrl_q : 2'd0;
  assign bus.alu_a       = (state_q == S_ISSUE) ? a_q : '0;
  assign bus.alu_b       = (state_q == S_ISSUE) ? b_q : '0;
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_y       = (state_q == S_RESP) ? y_q : '0;
  assign bus.rsp_err     = (state_q == S_RESP) & err_q;
  assign busy_o          = (state_q != S_IDLE);
endmodule
